// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parametrised pipeline stage register with valid/ready, flush and optional skid entry
module pipe_stage_buf #(
    parameter int WIDTH      = 147,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] stall_q;
    logic             in_fire;
    logic             out_fire;

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends only on registered state, so stalls never ripple upstream combinationally.
            assign in_ready = (state != TWO);
        end else begin : g_noskid
            assign in_ready = (state == EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign stall_cnt = stall_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end

            if (flush) begin
                state <= EMPTY;
                if (CLEAR_DATA != 0) begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state  <= ONE;
                            main_q <= in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data;
                        end else if (in_fire) begin
                            state  <= TWO;
                            skid_q <= in_data;
                        end else if (out_fire) begin
                            state <= EMPTY;
                            if (CLEAR_DATA != 0) begin
                                main_q <= '0;
                            end
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            state  <= ONE;
                            main_q <= skid_q;
                            if (CLEAR_DATA != 0) begin
                                skid_q <= '0;
                            end
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf in skid, no-skid and narrow-counter builds
module tb_pipe_stage_buf;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // a and c share stimulus (SKID=1), c has a 4-bit stall counter; b is the SKID=0 build
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic [15:0]  a_stall;
    logic         c_in_ready, c_out_valid;
    logic [W-1:0] c_out_data;
    logic [1:0]   c_occ;
    logic [3:0]   c_stall;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .flush(a_flush),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(c_in_ready), .in_data(a_in_data),
        .out_valid(c_out_valid), .out_ready(a_out_ready), .out_data(c_out_data), .flush(a_flush),
        .occupancy(c_occ), .stall_cnt(c_stall)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(0), .CLEAR_DATA(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .flush(b_flush),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int exp_sa = 0;
    int exp_sc = 0;
    int exp_sb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the models at the falling edge, then advance the models by one clock.
    task automatic step();
        bit ea_val, ea_rdy, eb_val, eb_rdy;
        logic [W-1:0] ea_dat, eb_dat;
        @(negedge clk);
        ea_val = (qa.size() != 0);
        ea_rdy = (qa.size() < 2);
        ea_dat = ea_val ? qa[0] : '0;
        eb_val = (qb.size() != 0);
        eb_rdy = !eb_val || b_out_ready;
        eb_dat = eb_val ? qb[0] : '0;

        chk("a_in_ready",  a_in_ready,  ea_rdy);
        chk("a_out_valid", a_out_valid, ea_val);
        chk("a_occupancy", a_occ,       qa.size());
        chk("a_out_data",  a_out_data,  ea_dat);
        chk("a_stall_cnt", a_stall,     exp_sa);
        chk("c_in_ready",  c_in_ready,  ea_rdy);
        chk("c_occupancy", c_occ,       qa.size());
        chk("c_out_data",  c_out_data,  ea_dat);
        chk("c_stall_cnt", c_stall,     exp_sc);
        chk("b_in_ready",  b_in_ready,  eb_rdy);
        chk("b_out_valid", b_out_valid, eb_val);
        chk("b_occupancy", b_occ,       qb.size());
        chk("b_out_data",  b_out_data,  eb_dat);
        chk("b_stall_cnt", b_stall,     exp_sb);

        if (ea_val && !a_out_ready) begin
            if (exp_sa < 65535) exp_sa++;
            if (exp_sc < 15) exp_sc++;
        end
        if (ea_val && a_out_ready) void'(qa.pop_front());
        if (a_flush) qa.delete();
        else if (a_in_valid && ea_rdy) qa.push_back(a_in_data);

        if (eb_val && !b_out_ready && exp_sb < 65535) exp_sb++;
        if (eb_val && b_out_ready) void'(qb.pop_front());
        if (b_flush) qb.delete();
        else if (b_in_valid && eb_rdy) qb.push_back(b_in_data);

        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        #3;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_occupancy", a_occ, 0);
        chk("rst_a_in_ready",  a_in_ready, 1);
        chk("rst_a_out_data",  a_out_data, 0);
        chk("rst_b_in_ready",  b_in_ready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // pass-through
        a_out_ready = 1'b1;
        for (int d = 1; d <= 3; d++) begin
            a_in_valid = 1'b1;
            a_in_data  = W'(d);
            step();
        end
        a_in_valid = 1'b0;
        repeat (2) step();

        // skid fill then drain
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h0A; step();
        a_in_data = 8'h0B; step();
        a_in_valid = 1'b0;
        repeat (2) step();
        a_out_ready = 1'b1;
        repeat (3) step();

        // flush with a simultaneous push
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h0A; step();
        a_in_data = 8'h0B; step();
        a_in_data = 8'h0C; a_flush = 1'b1; step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        step();
        a_out_ready = 1'b1;
        repeat (2) step();

        // SKID=0 build with toggling out_ready
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h05; step();
        b_out_ready = 1'b0; b_in_data = 8'h06; step();
        b_out_ready = 1'b1; step();
        b_in_valid = 1'b0;
        repeat (2) step();

        // asynchronous reset between edges with two entries held
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11; step();
        a_in_data = 8'h22; step();
        a_in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst_a_out_valid", a_out_valid, 0);
        chk("arst_a_occupancy", a_occ, 0);
        chk("arst_a_stall_cnt", a_stall, 0);
        chk("arst_a_in_ready",  a_in_ready, 1);
        chk("arst_a_out_data",  a_out_data, 0);
        chk("arst_c_stall_cnt", c_stall, 0);
        qa.delete(); qb.delete();
        exp_sa = 0; exp_sc = 0; exp_sb = 0;
        reset = 1'b1;
        step();

        // stall counter saturation on the 4-bit build
        a_in_valid = 1'b1; a_in_data = 8'h33; step();
        a_in_valid = 1'b0;
        repeat (20) step();
        chk("c_stall_saturated", c_stall, 15);
        a_out_ready = 1'b1;
        repeat (2) step();

        // random traffic on both builds
        for (int i = 0; i < 300; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = W'($urandom);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = W'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
